adc_sample_sequencer: RTL and testbench
=======================================

# adc_sample_sequencer

- Paces ADC conversions at a programmable interval: issues `adc_req` pulses, waits for the `adc_rdy` handshake and captures `adc_dat`.
- Each sample is stamped with a free-running cycle timestamp and presented to the trigger/surround cache over a valid/ready port.
- Sits between the ADC front-end and the cache, replacing hand-driven request pulses.
- Also flags missing conversions (timeout) and samples dropped under back-pressure (overrun).

## Interface
Parameters:
- `DW`, 8, ADC sample width
- `TSW`, 32, timestamp width
- `PW`, 16, period register width
- `TMO`, 15, max cycles to wait for `adc_rdy` after a request

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level enable; high = run conversions
- `period`  in  PW  clocks between successive request pulses; 0 treated as 1
- `adc_req`  out  1  one-cycle conversion request to ADC
- `adc_rdy`  in  1  ADC data-valid, synchronous to `clk`
- `adc_dat`  in  DW  ADC sample, valid while `adc_rdy`=1
- `smp_valid`  out  1  sample available to cache
- `smp_ready`  in  1  cache accepts sample
- `smp_data`  out  DW  captured sample
- `smp_time`  out  TSW  timestamp of the request that produced the sample
- `busy`  out  1  state ≠ IDLE
- `tmo_err`  out  1  one-cycle pulse on conversion timeout
- `ovr_cnt`  out  8  dropped-sample count, saturates at 255

## Operation
- Reset values: `adc_req`=0, `smp_valid`=0, `smp_data`=0, `smp_time`=0, `busy`=0, `tmo_err`=0, `ovr_cnt`=0, timestamp counter=0, state IDLE.
- Timestamp counter: TSW bits, +1 every cycle from reset release, wraps 2^TSW−1 → 0 silently.
- State machine:
  - IDLE: when `start`=1 → REQ.
  - REQ: `adc_req`=1 for exactly this cycle. Latch timestamp into `req_time`. Load period counter with max(`period`,1)−1 and timeout counter with TMO. → WAIT.
  - WAIT: `adc_rdy`=1 → capture, → HOLD. Timeout counter reaches 0 with no rdy → pulse `tmo_err`, discard, → HOLD.
  - HOLD: period counter = 0 → REQ if `start`=1, else IDLE.
- Period counter: decrements every cycle from REQ+1 until 0, including through WAIT. If the conversion outlasts `period`, the next REQ follows HOLD immediately; the effective period is stretched, never shortened.
- Capture:
  - Output register empty, or being accepted this cycle (`smp_valid`&`smp_ready`): load `smp_data`=`adc_dat`, `smp_time`=`req_time`, `smp_valid`=1.
  - Otherwise the new sample is dropped, the held sample is kept, and `ovr_cnt`++ (saturating).
- `smp_valid` clears on a cycle with `smp_ready`=1 and no simultaneous capture.
- `start` falling mid-conversion: WAIT completes (capture or timeout), then HOLD → IDLE; no further REQ. `start` re-asserted in HOLD is honoured normally.
- `period` is sampled only in REQ; changes take effect on the next request.
- `adc_rdy` outside WAIT is ignored.
- Asynchronous reset mid-operation: all state returns to reset values immediately and an in-flight sample is lost.

## Timing
- `start` high sampled at edge N → `adc_req` high during cycle N+1.
- `adc_rdy` high sampled at edge K in WAIT → `smp_valid`/`smp_data` updated after edge K (visible cycle K+1).
- Request-to-request spacing = max(`period`, conversion time + 2) cycles.
- Timeout: no `adc_rdy` in TMO cycles after REQ → `tmo_err` pulses in cycle REQ+TMO+1.
- Output register is a single entry: no skid buffer, no combinational path from `smp_ready` to `smp_valid`.

## Structure
- Package `adc_seq_pkg` holds:
  - state encoding (IDLE, REQ, WAIT, HOLD)
  - default widths DW/TSW/PW
  - TMO default
  - OVR_MAX=255
- One sub-module, `sample_hold_reg`: the single-entry valid/ready output register with drop and overrun count. The FSM, timestamp counter and period/timeout counters live in the top.

## Test plan
- `period`=10, ADC answers rdy 3 cycles after req, `smp_ready`=1 → `adc_req` pulses exactly every 10 cycles; `smp_time` deltas = 10; `ovr_cnt`=0.
- `period`=2, rdy after 5 cycles → spacing stretches to 7 cycles; no sample lost; `tmo_err` never pulses.
- `adc_rdy` held 0, TMO=15 → `tmo_err` one-cycle pulse 16 cycles after each `adc_req`; `smp_valid` stays 0; requests continue.
- `smp_ready`=0 for 4 conversions after the first capture → `smp_data` keeps first sample; `ovr_cnt`=3. Capture on the exact cycle `smp_ready` rises is accepted, not counted.
- Drop `start` during WAIT → that sample still delivered; no further `adc_req`; `busy` falls after HOLD drains.
- Assert `reset`=0 during WAIT with `smp_valid`=1 → all outputs return to reset values at once; after release the timestamp restarts from 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding and default widths for the ADC sample sequencer
package adc_seq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  localparam int DW_DEF  = 8;
  localparam int TSW_DEF = 32;
  localparam int PW_DEF  = 16;
  localparam int TMO_DEF = 15;
  localparam int OVR_MAX = 255;
endpackage

// File: rtl/sample_hold_reg.sv
// sample_hold_reg: single-entry valid/ready output register; drops new samples when full and counts them
module sample_hold_reg
  import adc_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TSW = TSW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cap_i,
  input  logic [DW-1:0]  dat_i,
  input  logic [TSW-1:0] time_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic [DW-1:0]  data_o,
  output logic [TSW-1:0] time_o,
  output logic [7:0]     ovr_o
);
  logic           valid_q, valid_d, load;
  logic [DW-1:0]  data_q, data_d;
  logic [TSW-1:0] time_q, time_d;
  logic [7:0]     ovr_q, ovr_d;
  // a slot being drained this cycle may be refilled on the same edge
  always_comb begin
    load    = cap_i && (!valid_q || ready_i);
    valid_d = load || (valid_q && !ready_i);
    data_d  = load ? dat_i : data_q;
    time_d  = load ? time_i : time_q;
    ovr_d   = (cap_i && !load && ovr_q != 8'(OVR_MAX)) ? ovr_q + 8'd1 : ovr_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      time_q  <= '0;
      ovr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      time_q  <= time_d;
      ovr_q   <= ovr_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign time_o  = time_q;
  assign ovr_o   = ovr_q;
endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paces ADC requests, waits for rdy with timeout, and
// hands timestamped samples to the cache through a single-entry output register
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TSW = TSW_DEF,
  parameter int PW  = PW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [PW-1:0]  period,
  output logic           adc_req,
  input  logic           adc_rdy,
  input  logic [DW-1:0]  adc_dat,
  output logic           smp_valid,
  input  logic           smp_ready,
  output logic [DW-1:0]  smp_data,
  output logic [TSW-1:0] smp_time,
  output logic           busy,
  output logic           tmo_err,
  output logic [7:0]     ovr_cnt
);
  localparam int TW = ($clog2(TMO) > 0) ? $clog2(TMO) : 1;
  state_e         state_q;
  logic [TSW-1:0] ts_q, req_time_q;
  logic [PW-1:0]  pcnt_q;
  logic [TW-1:0]  tcnt_q;
  logic           adc_req_q, busy_q, tmo_err_q, cap;
  assign cap = (state_q == WAIT) && adc_rdy;
  // counters are loaded one below their nominal value because the REQ edge
  // already counts as the first elapsed cycle; HOLD then reads exact spacing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      req_time_q <= '0;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      adc_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      ts_q      <= ts_q + 1'b1;
      adc_req_q <= 1'b0;
      tmo_err_q <= 1'b0;
      if (pcnt_q != '0) pcnt_q <= pcnt_q - 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= REQ;
          adc_req_q <= 1'b1;
          busy_q    <= 1'b1;
        end
        REQ: begin
          state_q    <= WAIT;
          req_time_q <= ts_q;
          pcnt_q     <= (period > PW'(1)) ? period - PW'(2) : '0;
          tcnt_q     <= TW'(TMO - 1);
        end
        WAIT: if (adc_rdy) state_q <= HOLD;
          else if (tcnt_q == '0) begin
            state_q   <= HOLD;
            tmo_err_q <= 1'b1;
          end else tcnt_q <= tcnt_q - 1'b1;
        HOLD: if (pcnt_q == '0) begin
          state_q   <= start ? REQ : IDLE;
          adc_req_q <= start;
          busy_q    <= start;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  sample_hold_reg #(.DW(DW), .TSW(TSW)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .cap_i   (cap),
    .dat_i   (adc_dat),
    .time_i  (req_time_q),
    .ready_i (smp_ready),
    .valid_o (smp_valid),
    .data_o  (smp_data),
    .time_o  (smp_time),
    .ovr_o   (ovr_cnt)
  );
  assign adc_req = adc_req_q;
  assign busy    = busy_q;
  assign tmo_err = tmo_err_q;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed checks of pacing, timeout, back-pressure, stop and reset
module tb_adc_sample_sequencer;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, adc_rdy = 1'b0, smp_ready = 1'b0;
  logic [15:0] period = 16'd10;
  logic [7:0]  adc_dat = 8'h00;
  logic        adc_req, smp_valid, busy, tmo_err;
  logic [7:0]  smp_data, ovr_cnt;
  logic [31:0] smp_time;
  int cyc = 0, last_req = 0, n_cmp = 0, n_err = 0, tmo_cnt = 0, n = 0;

  adc_sample_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .period    (period),
    .adc_req   (adc_req),
    .adc_rdy   (adc_rdy),
    .adc_dat   (adc_dat),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_data  (smp_data),
    .smp_time  (smp_time),
    .busy      (busy),
    .tmo_err   (tmo_err),
    .ovr_cnt   (ovr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (reset && tmo_err) tmo_cnt <= tmo_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // called in a REQ cycle; ADC answers lat cycles later, returns in the cycle after capture
  task automatic convert(input int lat, input logic [7:0] d);
    repeat (lat) step();
    adc_rdy = 1'b1;
    adc_dat = d;
    step();
    adc_rdy = 1'b0;
  endtask

  task automatic next_req(input string tag, input int exp);
    int k = 0;
    while (adc_req !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    chk(tag, cyc - last_req, exp);
    last_req = cyc;
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(adc_req), 0);
    chk("rst_valid", 32'(smp_valid), 0);
    chk("rst_data", 32'(smp_data), 0);
    chk("rst_time", smp_time, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_ovr", 32'(ovr_cnt), 0);
    step();
    reset = 1'b1;
    start = 1'b1;
    smp_ready = 1'b1;
    step();
    chk("first_req", 32'(adc_req), 1);
    chk("first_busy", 32'(busy), 1);
    last_req = cyc;
    // period 10, rdy after 3 cycles
    for (int k = 0; k < 3; k++) begin
      convert(3, 8'(8'hA0 + k));
      chk("t1_valid", 32'(smp_valid), 1);
      chk("t1_data", 32'(smp_data), 8'hA0 + k);
      chk("t1_time", smp_time, 1 + 10 * k);
      step();
      chk("t1_clr", 32'(smp_valid), 0);
      if (k == 2) period = 16'd2;
      next_req("t1_space", 10);
    end
    chk("t1_ovr", 32'(ovr_cnt), 0);
    // period 2, rdy after 5 cycles: spacing stretches to 7
    for (int k = 0; k < 2; k++) begin
      convert(5, 8'(8'h50 + k));
      chk("t2_data", 32'(smp_data), 8'h50 + k);
      chk("t2_time", smp_time, 31 + 7 * k);
      next_req("t2_space", 7);
    end
    chk("t2_no_tmo", tmo_cnt, 0);
    // no rdy: timeout pulse in REQ+16
    repeat (15) step();
    chk("t3_pre", 32'(tmo_err), 0);
    step();
    chk("t3_tmo", 32'(tmo_err), 1);
    chk("t3_valid", 32'(smp_valid), 0);
    step();
    chk("t3_pulse", 32'(tmo_err), 0);
    next_req("t3_space", 17);
    // rdy on the last waiting cycle is still a capture
    convert(15, 8'hE7);
    chk("t3b_valid", 32'(smp_valid), 1);
    chk("t3b_data", 32'(smp_data), 8'hE7);
    chk("t3b_time", smp_time, 62);
    chk("t3b_tmo", 32'(tmo_err), 0);
    chk("t3b_tmo_cnt", tmo_cnt, 1);
    next_req("t3b_space", 17);
    // back-pressure: first sample held, three dropped
    smp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      convert(3, 8'(8'hB0 + k));
      chk("t4_data", 32'(smp_data), 8'hB0);
      chk("t4_time", smp_time, 79);
      chk("t4_ovr", 32'(ovr_cnt), k);
      next_req("t4_space", 5);
    end
    repeat (3) step();
    adc_rdy = 1'b1;
    adc_dat = 8'hB4;
    smp_ready = 1'b1;
    step();
    adc_rdy = 1'b0;
    chk("t4_acc_valid", 32'(smp_valid), 1);
    chk("t4_acc_data", 32'(smp_data), 8'hB4);
    chk("t4_acc_time", smp_time, 99);
    chk("t4_acc_ovr", 32'(ovr_cnt), 3);
    next_req("t4_space_last", 5);
    // drop start mid-conversion
    step();
    start = 1'b0;
    convert(2, 8'hC5);
    chk("t5_data", 32'(smp_data), 8'hC5);
    chk("t5_time", smp_time, 104);
    chk("t5_busy_hold", 32'(busy), 1);
    step();
    chk("t5_busy_off", 32'(busy), 0);
    n = 0;
    repeat (20) begin
      step();
      if (adc_req) n++;
    end
    chk("t5_noreq", n, 0);
    // reset during WAIT with a held sample
    period = 16'd10;
    smp_ready = 1'b0;
    start = 1'b1;
    step();
    chk("t6_start", 32'(adc_req), 1);
    last_req = cyc;
    convert(2, 8'h66);
    chk("t6_held", 32'(smp_valid), 1);
    next_req("t6_space", 10);
    step();
    chk("t6_pre", 32'(smp_valid), 1);
    reset = 1'b0;
    #2;
    chk("t6_valid", 32'(smp_valid), 0);
    chk("t6_data", 32'(smp_data), 0);
    chk("t6_time", smp_time, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ovr", 32'(ovr_cnt), 0);
    chk("t6_req", 32'(adc_req), 0);
    step();
    reset = 1'b1;
    smp_ready = 1'b1;
    step();
    chk("t6_restart", 32'(adc_req), 1);
    convert(3, 8'h77);
    chk("t6_rdata", 32'(smp_data), 8'h77);
    chk("t6_rtime", smp_time, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
